// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 column shift register,
// border taps zeroed by default or edge-replicated when REPLICATE_BORDER_EN is defined.
module window_3x3_gen #(
    parameter int WIDTH  = 512,
    parameter int HEIGHT = 512,
    parameter int PW     = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PW-1:0]   input_pixel,
    input  logic            input_is_valid,
    output logic            in_ready,
    output logic [9*PW-1:0] out_window,
    output logic            output_is_valid,
    output logic            frame_done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t          state_reg;
    logic [CW-1:0]   in_col_reg, out_col_reg;
    logic [RW-1:0]   in_row_reg, out_row_reg;
    logic            in_ready_reg;
    logic [PW-1:0]   lb1_mem [WIDTH];
    logic [PW-1:0]   lb2_mem [WIDTH];
    logic [PW-1:0]   lb1_rd_reg, lb2_rd_reg;
    logic [PW-1:0]   col_p1_reg [3];
    logic [PW-1:0]   col_p2_reg [3];
    logic [PW-1:0]   new_col [3];
    logic [PW-1:0]   tap [9];
    logic [PW-1:0]   win_tap [9];
    logic [9*PW-1:0] win_flat;

    logic          accept, advance, emit, in_col_last, out_last;
    logic          top_edge, bot_edge, left_edge, right_edge;
    logic [CW-1:0] col_next;

    assign accept      = input_is_valid && in_ready_reg;
    assign advance     = accept || (state_reg == FLUSH);
    assign emit        = (accept && state_reg == RUN) || (state_reg == FLUSH);
    assign in_col_last = (in_col_reg == CW'(WIDTH - 1));
    assign col_next    = in_col_last ? '0 : in_col_reg + CW'(1);
    assign top_edge    = (out_row_reg == '0);
    assign bot_edge    = (out_row_reg == RW'(HEIGHT - 1));
    assign left_edge   = (out_col_reg == '0);
    assign right_edge  = (out_col_reg == CW'(WIDTH - 1));
    assign out_last    = bot_edge && right_edge;

    // Newest column: two rows above from the line buffers, current row from the input.
    assign new_col[0] = lb2_rd_reg;
    assign new_col[1] = lb1_rd_reg;
    assign new_col[2] = (state_reg == FLUSH) ? '0 : input_pixel;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cols
        assign tap[3*gi+0] = col_p2_reg[gi];
        assign tap[3*gi+1] = col_p1_reg[gi];
        assign tap[3*gi+2] = new_col[gi];
    end

`ifdef REPLICATE_BORDER_EN
    logic [PW-1:0] row_fix [9];
    for (genvar gi = 0; gi < 9; gi++) begin : g_pad
        localparam int DR = gi / 3;
        localparam int DC = gi % 3;
        assign row_fix[gi] = ((DR == 0 && top_edge) || (DR == 2 && bot_edge))
                             ? tap[3 + DC] : tap[gi];
        assign win_tap[gi] = ((DC == 0 && left_edge) || (DC == 2 && right_edge))
                             ? row_fix[3*DR + 1] : row_fix[gi];
    end
`else
    for (genvar gi = 0; gi < 9; gi++) begin : g_pad
        localparam int DR = gi / 3;
        localparam int DC = gi % 3;
        assign win_tap[gi] = ((DR == 0 && top_edge) || (DR == 2 && bot_edge) ||
                              (DC == 0 && left_edge) || (DC == 2 && right_edge))
                             ? '0 : tap[gi];
    end
`endif

    for (genvar gi = 0; gi < 9; gi++) begin : g_pack
        assign win_flat[PW*gi +: PW] = win_tap[gi];
    end

    // Read address runs one column ahead so each read is registered before it is needed.
    always_ff @(posedge clk) begin
        if (advance) begin
            lb1_mem[in_col_reg] <= new_col[2];
            lb2_mem[in_col_reg] <= lb1_rd_reg;
            lb1_rd_reg          <= lb1_mem[col_next];
            lb2_rd_reg          <= lb2_mem[col_next];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= FILL;
            in_col_reg      <= '0;
            in_row_reg      <= '0;
            out_col_reg     <= '0;
            out_row_reg     <= '0;
            in_ready_reg    <= 1'b1;
            out_window      <= '0;
            output_is_valid <= 1'b0;
            frame_done      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                col_p1_reg[i] <= '0;
                col_p2_reg[i] <= '0;
            end
        end else begin
            output_is_valid <= emit;
            frame_done      <= emit && out_last;
            if (emit) begin
                out_window <= win_flat;
                if (out_last) begin
                    out_col_reg <= '0;
                    out_row_reg <= '0;
                end else if (right_edge) begin
                    out_col_reg <= '0;
                    out_row_reg <= out_row_reg + RW'(1);
                end else begin
                    out_col_reg <= out_col_reg + CW'(1);
                end
            end
            if (advance) begin
                for (int i = 0; i < 3; i++) begin
                    col_p2_reg[i] <= col_p1_reg[i];
                    col_p1_reg[i] <= new_col[i];
                end
                in_col_reg <= col_next;
                if (in_col_last && state_reg != FLUSH)
                    in_row_reg <= in_row_reg + RW'(1);
            end
            case (state_reg)
                FILL: begin
                    if (accept && in_row_reg != '0)
                        state_reg <= RUN;
                end
                RUN: begin
                    if (accept && in_col_last && in_row_reg == RW'(HEIGHT - 1)) begin
                        state_reg    <= FLUSH;
                        in_ready_reg <= 1'b0;
                        in_row_reg   <= '0;
                    end
                end
                FLUSH: begin
                    if (out_last) begin
                        state_reg    <= FILL;
                        in_ready_reg <= 1'b1;
                        in_col_reg   <= '0;
                        in_row_reg   <= '0;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    assign in_ready = in_ready_reg;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 4x4 frame; honours REPLICATE_BORDER_EN when defined.
module tb_window_3x3_gen;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 24;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [PW-1:0]   input_pixel = '0;
    logic            input_is_valid = 1'b0;
    logic            in_ready;
    logic [9*PW-1:0] out_window;
    logic            output_is_valid;
    logic            frame_done;

    int tests = 0;
    int fails = 0;
    int win_idx, acc_cnt, ready_low_cnt;
    logic [9*PW-1:0] hand_w [16];
    bit              hand_has [16];

    window_3x3_gen #(.WIDTH(W), .HEIGHT(H), .PW(PW)) dut (
        .clk(clk),
        .rst(rst),
        .input_pixel(input_pixel),
        .input_is_valid(input_is_valid),
        .in_ready(in_ready),
        .out_window(out_window),
        .output_is_valid(output_is_valid),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [9*PW-1:0] pack9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {24'(a8), 24'(a7), 24'(a6), 24'(a5), 24'(a4), 24'(a3), 24'(a2), 24'(a1), 24'(a0)};
    endfunction

    function automatic logic [9*PW-1:0] exp_win(input int idx);
        logic [9*PW-1:0] w;
        int r, c, rr, cc;
        r = idx / W;
        c = idx % W;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            rr = r + k / 3 - 1;
            cc = c + k % 3 - 1;
`ifdef REPLICATE_BORDER_EN
            rr = (rr < 0) ? 0 : ((rr > H - 1) ? H - 1 : rr);
            cc = (cc < 0) ? 0 : ((cc > W - 1) ? W - 1 : cc);
            w[24*k +: 24] = 24'(rr * W + cc);
`else
            if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                w[24*k +: 24] = 24'(rr * W + cc);
`endif
        end
        return w;
    endfunction

    task automatic check_w(input string tag, input logic [9*PW-1:0] obs, input logic [9*PW-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_i(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic collect();
        if (output_is_valid) begin
            if (win_idx == 0) check_i("first_latency_pixels", acc_cnt, 6);
            if (win_idx < 16) begin
                check_w("window_model", out_window, exp_win(win_idx));
                if (hand_has[win_idx]) check_w("window_hand", out_window, hand_w[win_idx]);
            end
            check_i("frame_done_pos", {31'b0, frame_done}, (win_idx == 15) ? 1 : 0);
            if (frame_done) check_i("ready_at_done", {31'b0, in_ready}, 1);
            $display("[TB] window %0d centre (%0d,%0d) data %h", win_idx, win_idx / W, win_idx % W, out_window);
            win_idx++;
        end
        if (!in_ready) ready_low_cnt++;
    endtask

    task automatic tick();
        bit acc;
        acc = input_is_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) acc_cnt++;
        collect();
    endtask

    task automatic run_frame(input bit toggle, input bit hold);
        int cyc;
        win_idx = 0;
        acc_cnt = 0;
        ready_low_cnt = 0;
        cyc = 0;
        while (win_idx < 16 && cyc < 300) begin
            if (acc_cnt < 16) begin
                input_is_valid = toggle ? (cyc % 2 == 0) : 1'b1;
                input_pixel    = 24'(acc_cnt);
            end else begin
                input_is_valid = hold;
                input_pixel    = 24'hABCDEF;
            end
            tick();
            cyc++;
        end
        check_i("frame_budget", (cyc < 300) ? 1 : 0, 1);
        input_is_valid = 1'b0;
        repeat (3) tick();
        check_i("window_count", win_idx, 16);
        check_i("pixels_consumed", acc_cnt, 16);
        check_i("flush_ready_low", ready_low_cnt, 5);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) hand_has[i] = 1'b0;
`ifdef REPLICATE_BORDER_EN
        hand_w[0]  = pack9(0, 0, 1, 0, 0, 1, 4, 4, 5);    hand_has[0]  = 1'b1;
        hand_w[15] = pack9(10, 11, 11, 14, 15, 15, 14, 15, 15); hand_has[15] = 1'b1;
`else
        hand_w[0]  = pack9(0, 0, 0, 0, 0, 1, 0, 4, 5);    hand_has[0]  = 1'b1;
        hand_w[5]  = pack9(0, 1, 2, 4, 5, 6, 8, 9, 10);   hand_has[5]  = 1'b1;
        hand_w[7]  = pack9(2, 3, 0, 6, 7, 0, 10, 11, 0);  hand_has[7]  = 1'b1;
        hand_w[15] = pack9(10, 11, 0, 14, 15, 0, 0, 0, 0); hand_has[15] = 1'b1;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_w("reset_window", out_window, '0);
        check_i("reset_valid", {31'b0, output_is_valid}, 0);
        check_i("reset_done", {31'b0, frame_done}, 0);
        check_i("reset_ready", {31'b0, in_ready}, 1);
        @(negedge clk);
        rst = 1'b1;

        // Continuous stream, including flush and frame_done
        $display("[TB] frame: continuous valid");
        run_frame(1'b0, 1'b0);

        // Toggling valid, valid held high across the flush
        $display("[TB] frame: toggling valid, held during flush");
        run_frame(1'b1, 1'b1);

        // Following frame must start cleanly at (0,0)
        $display("[TB] frame: continuous after toggled frame");
        run_frame(1'b0, 1'b0);

        // Mid-frame reset after 7 pixels of distinct data
        $display("[TB] mid-frame reset");
        for (int i = 0; i < 7; i++) begin
            input_is_valid = 1'b1;
            input_pixel    = 24'h800000 + 24'(i);
            @(posedge clk);
            #1;
        end
        input_is_valid = 1'b0;
        check_i("pre_reset_valid", {31'b0, output_is_valid}, 1);
        #2;
        rst = 1'b0;
        #1;
        check_w("async_reset_window", out_window, '0);
        check_i("async_reset_valid", {31'b0, output_is_valid}, 0);
        check_i("async_reset_done", {31'b0, frame_done}, 0);
        check_i("async_reset_ready", {31'b0, in_ready}, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_frame(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
